// File: rtl/or10_divider_requester_if.sv
// AXI-Stream channels between the OR10 divider requester and the external divider.
// Valid/ready rule for the dividend and divisor channels: a beat transfers on a
// rising edge where tvalid and tready are both high; once tvalid rises it stays
// high with tdata stable until that beat (only reset may retract it), and tready
// may depend on tvalid. The dout channel has no tready: a tvalid cycle is a beat.
interface or10_divider_requester_if;
    logic        m_axis_dividend_tvalid;
    logic        m_axis_dividend_tready;
    logic [39:0] m_axis_dividend_tdata;
    logic        m_axis_divisor_tvalid;
    logic        m_axis_divisor_tready;
    logic [39:0] m_axis_divisor_tdata;
    logic        s_axis_dout_tvalid;
    logic [79:0] s_axis_dout_tdata;

    modport master (
        output m_axis_dividend_tvalid, m_axis_dividend_tdata,
        input  m_axis_dividend_tready,
        output m_axis_divisor_tvalid, m_axis_divisor_tdata,
        input  m_axis_divisor_tready,
        input  s_axis_dout_tvalid, s_axis_dout_tdata
    );

    modport slave (
        input  m_axis_dividend_tvalid, m_axis_dividend_tdata,
        output m_axis_dividend_tready,
        input  m_axis_divisor_tvalid, m_axis_divisor_tdata,
        output m_axis_divisor_tready,
        output s_axis_dout_tvalid, s_axis_dout_tdata
    );
endinterface

// File: rtl/or10_divider_requester.sv
// CPU-side requester for the OR10 external divider: extends the 32-bit operands
// to 40 bits, sends them on two independent AXI-Stream channels, captures the
// 80-bit dout beat and returns quotient/remainder plus status with a done pulse.
module or10_divider_requester #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        timeout,
    output logic [1:0]  state_dbg,
    or10_divider_requester_if.master axis
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        dvd_valid_q, dvs_valid_q;
    logic [39:0] dvd_data_q, dvs_data_q;
    logic        ovf_q;
    logic        discard_q;
    logic [CNT_W-1:0] cnt_q;

    logic        pending, accept, zero_div, beats_done, capture, timeout_hit, load_res;
    logic [31:0] res_quo, res_rem;
    logic        res_dbz, res_ovf, res_to;

    // A channel is still outstanding after this edge only if it is valid and not accepted.
    assign pending     = dvd_valid_q | dvs_valid_q;
    assign beats_done  = ~(dvd_valid_q & ~axis.m_axis_dividend_tready) &
                         ~(dvs_valid_q & ~axis.m_axis_divisor_tready);
    assign zero_div    = (divisor == 32'd0);
    // A timed-out request may leave channels outstanding; no new request until they drain.
    assign accept      = (state_q == S_IDLE) & start & ~pending;
    assign capture     = axis.s_axis_dout_tvalid &
                         (((state_q == S_SEND) & beats_done) | (state_q == S_WAIT));
    assign timeout_hit = TO_EN & (cnt_q == TO_LAST);

    assign axis.m_axis_dividend_tvalid = dvd_valid_q;
    assign axis.m_axis_dividend_tdata  = dvd_data_q;
    assign axis.m_axis_divisor_tvalid  = dvs_valid_q;
    assign axis.m_axis_divisor_tdata   = dvs_data_q;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; a dout beat wins over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = zero_div ? S_FINISH : S_SEND;
            S_SEND: begin
                if (capture || timeout_hit) state_d = S_FINISH;
                else if (beats_done)        state_d = S_WAIT;
            end
            S_WAIT:   if (capture || timeout_hit) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status outputs; abort seen during FINISH also hides the pulse.
    always_comb begin
        busy      = (state_q != S_IDLE) | pending;
        done      = (state_q == S_FINISH) & ~discard_q & ~abort;
        state_dbg = state_q;
    end

    // Result to commit on entry to FINISH: zero divisor, divider beat, or timeout.
    always_comb begin
        res_quo = 32'hDEADF00D;
        res_rem = 32'd0;
        res_dbz = 1'b0;
        res_ovf = 1'b0;
        res_to  = 1'b1;
        if (state_q == S_IDLE) begin
            res_quo = 32'd0;
            res_rem = dividend;
            res_dbz = 1'b1;
            res_to  = 1'b0;
        end else if (capture) begin
            res_quo = ovf_q ? 32'h80000000 : axis.s_axis_dout_tdata[71:40];
            res_rem = ovf_q ? 32'd0 : axis.s_axis_dout_tdata[31:0];
            res_ovf = ovf_q;
            res_to  = 1'b0;
        end
    end

    // Abort alongside start in IDLE never discards the request it starts.
    assign load_res = (state_d == S_FINISH) && (state_q != S_FINISH) &&
                      ((state_q == S_IDLE) || !(discard_q || abort));

    // Channel registers, timeout counter, discard flag and result registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dvd_valid_q <= 1'b0;
            dvs_valid_q <= 1'b0;
            dvd_data_q  <= '0;
            dvs_data_q  <= '0;
            ovf_q       <= 1'b0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            cnt_q <= ((state_q == S_SEND) || (state_q == S_WAIT)) ? cnt_q + CNT_W'(1) : '0;

            if (accept && !zero_div) begin
                dvd_valid_q <= 1'b1;
                dvs_valid_q <= 1'b1;
                dvd_data_q  <= is_signed ? {{8{dividend[31]}}, dividend} : {8'h00, dividend};
                dvs_data_q  <= is_signed ? {{8{divisor[31]}}, divisor} : {8'h00, divisor};
                ovf_q       <= is_signed && (dividend == 32'h80000000) && (divisor == 32'hFFFFFFFF);
            end else begin
                if (dvd_valid_q && axis.m_axis_dividend_tready) dvd_valid_q <= 1'b0;
                if (dvs_valid_q && axis.m_axis_divisor_tready)  dvs_valid_q <= 1'b0;
            end

            if (state_q == S_FINISH)                discard_q <= 1'b0;
            else if (abort && state_q != S_IDLE)    discard_q <= 1'b1;

            if (load_res) begin
                quotient    <= res_quo;
                remainder   <= res_rem;
                div_by_zero <= res_dbz;
                overflow    <= res_ovf;
                timeout     <= res_to;
            end
        end
    end

endmodule

// File: tb/tb_or10_divider_requester.sv
// Bench for or10_divider_requester: directed cases plus random requests, with a
// bench-side divider model answering the AXI channels and an arithmetic reference.
module tb_or10_divider_requester;

    localparam int TO = 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero, overflow, timeout;
    logic [31:0] quotient, remainder;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    or10_divider_requester_if axis();

    // Clock and watchdog.
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    or10_divider_requester #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .abort(abort),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow), .timeout(timeout),
        .state_dbg(state_dbg), .axis(axis.master)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request: drives start, answers both channels after the given ready delays,
    // returns the divider beat lat cycles after the last operand beat (never if no_dout),
    // and raises abort in cycle abort_cyc (0 = together with start, <0 = never).
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int dvd_dly, input int dvs_dly, input int lat,
                          input int abort_cyc, input bit no_dout);
        longint sa, sb, eq, er, dq, dr;
        logic [39:0] ea, eb, got_dvd, got_dvs;
        logic [31:0] q_o, r_o;
        logic [63:0] e;
        logic dz_o, ov_o, to_o, zero, discard, e_ov;
        int dvd_beats, dvs_beats, dvd_c, dvs_c, lb, done_n, done_cyc, saw_valid, unstable, exp_lat;
        dvd_beats = 0; dvs_beats = 0; dvd_c = -1; dvs_c = -1; lb = -1;
        done_n = 0; done_cyc = -1; saw_valid = 0; unstable = 0;
        q_o = '0; r_o = '0; dz_o = 0; ov_o = 0; to_o = 0; got_dvd = '0; got_dvs = '0;

        zero    = (b == 32'd0);
        discard = (abort_cyc > 0);
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        ea = sa[39:0];
        eb = sb[39:0];
        if (zero)         begin eq = 0; er = longint'(a); end
        else if (no_dout) begin eq = longint'(32'hDEADF00D); er = 0; end
        else              begin eq = sa / sb; er = sa % sb; end
        e_ov = !zero && !no_dout && sgn && a == 32'h80000000 && b == 32'hFFFFFFFF;
        exp_lat = zero ? 1 : (no_dout ? 1 + TO : 2 + ((dvd_dly > dvs_dly) ? dvd_dly : dvs_dly) + lat);
        if (!discard) exp_q.push_back({eq[31:0], er[31:0]});

        @(negedge aclk);
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        abort = (abort_cyc == 0);
        @(negedge aclk);
        start = 1'b0; abort = 1'b0;
        dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        for (int c = 1; c <= 14; c++) begin
            if (done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = c; q_o = quotient; r_o = remainder;
                    dz_o = div_by_zero; ov_o = overflow; to_o = timeout;
                end
            end
            abort = (c == abort_cyc);
            if (axis.m_axis_dividend_tvalid || axis.m_axis_divisor_tvalid) saw_valid++;
            if (axis.m_axis_dividend_tvalid && axis.m_axis_dividend_tdata !== ea) unstable++;
            if (axis.m_axis_divisor_tvalid && axis.m_axis_divisor_tdata !== eb) unstable++;
            axis.m_axis_dividend_tready = (c >= 1 + dvd_dly);
            axis.m_axis_divisor_tready  = (c >= 1 + dvs_dly);
            if (axis.m_axis_dividend_tvalid && axis.m_axis_dividend_tready) begin
                dvd_beats++;
                if (dvd_c < 0) begin dvd_c = c; got_dvd = axis.m_axis_dividend_tdata; end
            end
            if (axis.m_axis_divisor_tvalid && axis.m_axis_divisor_tready) begin
                dvs_beats++;
                if (dvs_c < 0) begin dvs_c = c; got_dvs = axis.m_axis_divisor_tdata; end
            end
            if (lb < 0 && dvd_c >= 0 && dvs_c >= 0) lb = (dvd_c > dvs_c) ? dvd_c : dvs_c;
            if (!no_dout && lb >= 0 && c == lb + lat) begin
                if (got_dvs == 40'd0) begin dq = 0; dr = 0; end
                else begin
                    dq = longint'($signed(got_dvd)) / longint'($signed(got_dvs));
                    dr = longint'($signed(got_dvd)) % longint'($signed(got_dvs));
                end
                axis.s_axis_dout_tvalid = 1'b1;
                axis.s_axis_dout_tdata  = {dq[39:0], dr[39:0]};
            end else begin
                axis.s_axis_dout_tvalid = 1'b0;
                axis.s_axis_dout_tdata  = {$urandom, $urandom, $urandom};
            end
            @(negedge aclk);
        end
        abort = 1'b0;
        axis.m_axis_dividend_tready = 1'b0;
        axis.m_axis_divisor_tready  = 1'b0;
        axis.s_axis_dout_tvalid     = 1'b0;

        check_val("done_count", done_n, discard ? 0 : 1);
        if (!discard) begin
            check_val("latency", done_cyc, exp_lat);
            if (exp_q.size() == 0) check_val("exp_q_empty", 1, 0);
            else begin
                e = exp_q.pop_front();
                check_val("quo_rem", {q_o, r_o}, e);
            end
            check_val("div_by_zero", dz_o, zero);
            check_val("overflow", ov_o, e_ov);
            check_val("timeout", to_o, !zero && no_dout);
            last_q = eq[31:0];
            last_r = er[31:0];
        end else begin
            check_val("held_result", {quotient, remainder}, {last_q, last_r});
        end
        if (zero) begin
            check_val("no_tvalid", saw_valid, 0);
        end else begin
            check_val("dividend_tdata", got_dvd, ea);
            check_val("divisor_tdata", got_dvs, eb);
            check_val("dividend_beats", dvd_beats, 1);
            check_val("divisor_beats", dvs_beats, 1);
            check_val("tdata_stable", unstable, 0);
        end
        check_val("idle_after", {busy, state_dbg}, 0);
    endtask

    // Main sequence.
    initial begin
        axis.m_axis_dividend_tready = 1'b0;
        axis.m_axis_divisor_tready  = 1'b0;
        axis.s_axis_dout_tvalid     = 1'b0;
        axis.s_axis_dout_tdata      = '0;

        repeat (3) @(negedge aclk);
        check_val("rst_outputs", {busy, done, div_by_zero, overflow, timeout,
                                  axis.m_axis_dividend_tvalid, axis.m_axis_divisor_tvalid}, 0);
        check_val("rst_results", {quotient, remainder}, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check_val("post_rst_idle", {busy, done, state_dbg}, 0);

        run_op(1'b0, 32'd100, 32'd7, 0, 0, 3, -1, 1'b0);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0, 2, -1, 1'b0);
        run_op(1'b0, 32'd5, 32'd0, 0, 0, 0, -1, 1'b0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 4, 1, 1, -1, 1'b0);
        run_op(1'b0, 32'd1234, 32'd5, 0, 0, 3, 2, 1'b0);
        run_op(1'b0, 32'd10, 32'd3, 0, 0, 1, -1, 1'b0);
        run_op(1'b0, 32'd77, 32'd9, 1, 0, 0, 0, 1'b0);
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0, 0, 0, -1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 200)) : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
                default: rb = $urandom;
            endcase
            run_op(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 3), -1, 1'b0);
        end

        // Reset while both channels are waiting for tready.
        @(negedge aclk);
        is_signed = 1'b0; dividend = 32'd40; divisor = 32'd4; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        @(negedge aclk);
        check_val("send_tvalids", {busy, axis.m_axis_dividend_tvalid, axis.m_axis_divisor_tvalid}, 3'b111);
        aresetn = 1'b0;
        #1;
        check_val("mid_rst_drop", {busy, done, axis.m_axis_dividend_tvalid,
                                   axis.m_axis_divisor_tvalid, state_dbg}, 0);
        check_val("mid_rst_results", {quotient, remainder}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        last_q = '0;
        last_r = '0;
        @(negedge aclk);

        run_op(1'b0, 32'd50, 32'd6, 0, 2, 2, -1, 1'b0);

        check_val("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
